// File: rtl/radix2_seq_divider.sv
// radix2_seq_divider: restoring divider, one quotient bit per cycle.
// Serves DIV/DIVU/REM/REMU for the execute stage.
module radix2_seq_divider #(
    parameter int SIZE = 33
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_signed,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            ready,
    output logic            valid,
    output logic            error,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder
);

    localparam int CW = $clog2(SIZE + 1);
    localparam logic [SIZE-1:0] MOST_NEG =
        {1'b1, {(SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        DONE,
        DONE_Z,
        DONE_OVF
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] rem_q;
    logic [SIZE-1:0] quo_q;
    logic [SIZE-1:0] div_mag;
    logic            neg_q;
    logic            neg_r;

    logic            a_neg;
    logic            b_neg;
    logic [SIZE-1:0] a_mag;
    logic [SIZE-1:0] b_mag;
    logic            is_ovf;
    logic [SIZE:0]   shifted;
    logic [SIZE-1:0] diff;
    logic            trial_ok;

    always_comb begin
        a_neg   = is_signed & dividend[SIZE-1];
        b_neg   = is_signed & divisor[SIZE-1];
        a_mag   = a_neg ? -dividend : dividend;
        b_mag   = b_neg ? -divisor : divisor;
        is_ovf  = is_signed
                && (dividend == MOST_NEG)
                && (divisor == '1);
        shifted = {rem_q, quo_q[SIZE-1]};
        // Partial remainder stays below the divisor,
        // so the kept difference always fits SIZE bits.
        trial_ok = shifted >= {1'b0, div_mag};
        diff     = shifted[SIZE-1:0] - div_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            valid     <= 1'b0;
            error     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_mag   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ready   <= 1'b0;
                        quo_q   <= a_mag;
                        rem_q   <= '0;
                        div_mag <= b_mag;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        cnt     <= CW'(SIZE);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            state     <= DONE_Z;
                        end else if (is_ovf) begin
                            quotient  <= dividend;
                            remainder <= '0;
                            state     <= DONE_OVF;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= trial_ok ? diff
                                      : shifted[SIZE-1:0];
                    quo_q <= {quo_q[SIZE-2:0], trial_ok};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= neg_q ? -quo_q : quo_q;
                    remainder <= neg_r ? -rem_q : rem_q;
                    valid     <= 1'b1;
                    state     <= DONE;
                end
                DONE_Z: begin
                    valid <= 1'b1;
                    error <= 1'b1;
                    state <= DONE;
                end
                DONE_OVF: begin
                    valid <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    valid <= 1'b0;
                    error <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix2_seq_divider.sv
// Bench for radix2_seq_divider: arithmetic model checked every cycle
// plus directed vectors with hand-computed results.
module tb_radix2_seq_divider;

    localparam int SIZE = 33;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            is_signed = 1'b0;
    logic [SIZE-1:0] dividend = '0;
    logic [SIZE-1:0] divisor = '0;
    logic            ready;
    logic            valid;
    logic            error;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;

    int n_cmp = 0;
    int n_bad = 0;

    radix2_seq_divider #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .valid     (valid),
        .error     (error),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [SIZE-1:0] act,
                       input logic [SIZE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Plain arithmetic: SV / and % truncate toward zero like RISC-V.
    function automatic void model_div(
        input  logic [SIZE-1:0] a,
        input  logic [SIZE-1:0] b,
        input  logic            s,
        output logic [SIZE-1:0] q,
        output logic [SIZE-1:0] r,
        output logic            e);
        longint sa, sb, tq, tr;
        if (b == '0) begin
            q = '1;
            r = a;
            e = 1'b1;
        end else begin
            sa = s ? {{31{a[SIZE-1]}}, a} : {31'b0, a};
            sb = s ? {{31{b[SIZE-1]}}, b} : {31'b0, b};
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[SIZE-1:0];
            r  = tr[SIZE-1:0];
            e  = 1'b0;
        end
    endfunction

    logic            m_ready = 1'b1;
    logic            m_valid = 1'b0;
    logic            m_err = 1'b0;
    logic [SIZE-1:0] m_q = '0;
    logic [SIZE-1:0] m_r = '0;
    logic [SIZE-1:0] p_q, p_r;
    logic            p_e;
    int              m_cnt = 0;
    bit              live = 0;

    always @(posedge clk) begin
        live = 1;
        if (reset) begin
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_q     = '0;
            m_r     = '0;
            m_cnt   = 0;
        end else if (m_valid) begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            if (start) begin
                model_div(dividend, divisor, is_signed,
                          p_q, p_r, p_e);
                m_ready = 1'b0;
                if (divisor == '0 ||
                    (is_signed && dividend == 33'h1_0000_0000
                     && divisor == '1)) begin
                    m_cnt = 1;
                    m_q   = p_q;
                    m_r   = p_r;
                end else begin
                    m_cnt = SIZE + 1;
                end
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1'b1;
                m_err   = p_e;
                m_q     = p_q;
                m_r     = p_r;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_ready", 33'(ready), 33'(m_ready));
            chk("m_valid", 33'(valid), 33'(m_valid));
            chk("m_error", 33'(error), 33'(m_err));
            chk("m_quot", quotient, m_q);
            chk("m_rem", remainder, m_r);
        end
    end

    task automatic run_op(input logic [SIZE-1:0] a,
                          input logic [SIZE-1:0] b,
                          input logic s,
                          input logic [SIZE-1:0] eq,
                          input logic [SIZE-1:0] er,
                          input logic ee,
                          input int elat);
        int n;
        bit seen;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = {$urandom, 1'b1};
        divisor  = {$urandom, 1'b0};
        n = 0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("valid_seen", 33'(seen), 33'(1));
        chk("latency", 33'(n), 33'(elat));
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("error", 33'(error), 33'(ee));
        @(negedge clk);
        chk("ready_after", 33'(ready), 33'(1));
    endtask

    initial begin
        int nv;
        logic [SIZE-1:0] cq, cr;
        repeat (2) @(negedge clk);
        chk("rst_ready", 33'(ready), 33'(1));
        chk("rst_valid", 33'(valid), 33'(0));
        chk("rst_quot", quotient, 33'h0);
        chk("rst_rem", remainder, 33'h0);
        reset = 1'b0;

        run_op(33'd100, 33'd7, 1'b0, 33'd14, 33'd2, 1'b0, 34);
        run_op(33'h1_FFFF_FFF9, 33'd2, 1'b1,
               33'h1_FFFF_FFFD, 33'h1_FFFF_FFFF, 1'b0, 34);
        run_op(33'd7, 33'h1_FFFF_FFFE, 1'b1,
               33'h1_FFFF_FFFD, 33'd1, 1'b0, 34);
        run_op(33'h1_FFFF_FFF9, 33'h1_FFFF_FFFE, 1'b1,
               33'd3, 33'h1_FFFF_FFFF, 1'b0, 34);
        run_op(33'd5, 33'd0, 1'b0,
               33'h1_FFFF_FFFF, 33'd5, 1'b1, 1);
        run_op(33'd5, 33'd0, 1'b1,
               33'h1_FFFF_FFFF, 33'd5, 1'b1, 1);
        run_op(33'h1_0000_0000, 33'h1_FFFF_FFFF, 1'b1,
               33'h1_0000_0000, 33'd0, 1'b0, 1);
        run_op(33'h1_0000_0000, 33'h1_FFFF_FFFF, 1'b0,
               33'd0, 33'h1_0000_0000, 1'b0, 34);
        run_op(33'h1_FFFF_FFFF, 33'd1, 1'b0,
               33'h1_FFFF_FFFF, 33'd0, 1'b0, 34);
        run_op(33'd3, 33'd10, 1'b0, 33'd0, 33'd3, 1'b0, 34);
        run_op(33'h1_0000_0000, 33'd1, 1'b1,
               33'h1_0000_0000, 33'd0, 1'b0, 34);
        run_op(33'h1_0000_0000, 33'd2, 1'b1,
               33'h1_8000_0000, 33'd0, 1'b0, 34);

        // Busy rejection: a start during CALC must be dropped.
        @(negedge clk);
        dividend  = 33'd100;
        divisor   = 33'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        dividend = 33'd9;
        divisor  = 33'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        cq = '0;
        cr = '0;
        for (int i = 0; i < 45; i++) begin
            if (valid) begin
                nv++;
                cq = quotient;
                cr = remainder;
            end
            @(negedge clk);
        end
        chk("busy_pulses", 33'(nv), 33'(1));
        chk("busy_quot", cq, 33'd14);
        chk("busy_rem", cr, 33'd2);
        run_op(33'd9, 33'd3, 1'b0, 33'd3, 33'd0, 1'b0, 34);

        // Reset mid-CALC aborts with no valid pulse.
        @(negedge clk);
        dividend = 33'd100;
        divisor  = 33'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 33'(ready), 33'(1));
        chk("abort_quot", quotient, 33'h0);
        chk("abort_rem", remainder, 33'h0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid) nv++;
            @(negedge clk);
        end
        chk("abort_pulses", 33'(nv), 33'(0));

        run_op(33'd100, 33'd7, 1'b0, 33'd14, 33'd2, 1'b0, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
